// File: rtl/at45_cmd_sequencer.sv
// AT45DBxx command sequencer: expands one host command into the opcode/address/data
// byte stream for the 9-bit SPI byte engine, including status polling after a program.
module at45_cmd_sequencer #(
    parameter int POLL_MAX = 4096,
    parameter int MAX_LEN  = 264
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        Cmd_Start,
    input  logic [1:0]  Cmd_Op,
    input  logic [23:0] Cmd_Addr,
    input  logic [8:0]  Cmd_Len,
    output logic        Busy,
    output logic        Cmd_Done,
    output logic        Cmd_Err,
    output logic [7:0]  Rd_Data,
    output logic        Rd_Valid,
    output logic        Wr_Req,
    input  logic [7:0]  Wr_Data,
    output logic        SPI_Start_Sig,
    output logic [8:0]  SPI_Data,
    input  logic        SPI_Done_Sig,
    input  logic [7:0]  SPI_Rdata
);
    localparam logic [1:0]  OP_STATUS = 2'b00;
    localparam logic [1:0]  OP_READ   = 2'b01;
    localparam logic [1:0]  OP_PROG   = 2'b10;
    localparam logic [8:0]  LEN_MAX   = 9'(MAX_LEN);
    localparam logic [12:0] POLL_LAST = 13'(POLL_MAX - 1);

    typedef enum logic [3:0] {
        IDLE, CHECK, LOAD, XFER, GAP, WFETCH, POLL, DONE, ERR
    } state_t;

    typedef enum logic [2:0] {
        PH_OPCODE, PH_ADDR, PH_DATA, PH_STAT_OP, PH_STAT_RD
    } phase_t;

    state_t      state_reg, state_next;
    phase_t      phase_reg;
    logic [1:0]  op_reg;
    logic [23:0] addr_reg;
    logic [8:0]  len_reg;
    logic [8:0]  byte_cnt_reg;
    logic [12:0] poll_cnt_reg;
    logic [1:0]  addr_idx_reg;
    logic        start_reg;
    logic [8:0]  spi_data_reg;
    logic [7:0]  rd_data_reg;
    logic        rd_valid_reg;

    logic        is_prog;
    logic        cmd_illegal;
    logic        last_byte;
    logic        poll_ready;
    logic [7:0]  addr_byte;
    logic [8:0]  load_word;

    assign is_prog     = (op_reg == OP_PROG);
    assign cmd_illegal = (op_reg == 2'b11) ||
                         ((op_reg != OP_STATUS) && ((len_reg == 9'd0) || (len_reg > LEN_MAX)));
    assign last_byte   = (byte_cnt_reg == (len_reg - 9'd1));
    assign poll_ready  = SPI_Rdata[7];

    always_comb begin
        case (addr_idx_reg)
            2'd0:    addr_byte = addr_reg[23:16];
            2'd1:    addr_byte = addr_reg[15:8];
            default: addr_byte = addr_reg[7:0];
        endcase
    end

    // Word presented in LOAD; program data words are placed by WFETCH instead.
    always_comb begin
        load_word = {last_byte, 8'hFF};
        case (phase_reg)
            PH_OPCODE:  load_word = is_prog ? 9'h082 : 9'h003;
            PH_ADDR:    load_word = {1'b0, addr_byte};
            PH_STAT_OP: load_word = 9'h0D7;
            PH_STAT_RD: load_word = 9'h1FF;
            default:    ;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (Cmd_Start) state_next = CHECK;
            CHECK:  state_next = cmd_illegal ? ERR : LOAD;
            LOAD:   state_next = XFER;
            XFER: begin
                if (SPI_Done_Sig) begin
                    state_next = GAP;
                    case (phase_reg)
                        PH_DATA: begin
                            if (last_byte) state_next = is_prog ? POLL : DONE;
                        end
                        PH_STAT_RD: begin
                            if (!is_prog || poll_ready)        state_next = DONE;
                            else if (poll_cnt_reg == POLL_LAST) state_next = ERR;
                            else                                state_next = POLL;
                        end
                        default: ;
                    endcase
                end
            end
            GAP:    state_next = ((phase_reg == PH_DATA) && is_prog) ? WFETCH : LOAD;
            WFETCH: state_next = LOAD;
            POLL:   state_next = LOAD;
            DONE:   state_next = IDLE;
            ERR:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            phase_reg    <= PH_OPCODE;
            op_reg       <= 2'b00;
            addr_reg     <= 24'h0;
            len_reg      <= 9'd0;
            byte_cnt_reg <= 9'd0;
            poll_cnt_reg <= 13'd0;
            addr_idx_reg <= 2'd0;
            start_reg    <= 1'b0;
            spi_data_reg <= 9'h000;
            rd_data_reg  <= 8'h00;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Command fields are captured with the request so the host may change them afterwards.
                    if (Cmd_Start) begin
                        op_reg   <= Cmd_Op;
                        addr_reg <= Cmd_Addr;
                        len_reg  <= Cmd_Len;
                    end
                end
                CHECK: begin
                    byte_cnt_reg <= 9'd0;
                    poll_cnt_reg <= 13'd0;
                    addr_idx_reg <= 2'd0;
                    phase_reg    <= (op_reg == OP_STATUS) ? PH_STAT_OP : PH_OPCODE;
                end
                LOAD: begin
                    if (!((phase_reg == PH_DATA) && is_prog)) spi_data_reg <= load_word;
                    start_reg <= 1'b1;
                end
                // Raising Start here keeps Wr_Req-to-Start at two cycles.
                WFETCH: begin
                    spi_data_reg <= {last_byte, Wr_Data};
                    start_reg    <= 1'b1;
                end
                XFER: begin
                    if (SPI_Done_Sig) begin
                        start_reg <= 1'b0;
                        case (phase_reg)
                            PH_OPCODE: phase_reg <= PH_ADDR;
                            PH_ADDR: begin
                                addr_idx_reg <= addr_idx_reg + 2'd1;
                                if (addr_idx_reg == 2'd2) phase_reg <= PH_DATA;
                            end
                            PH_DATA: begin
                                byte_cnt_reg <= byte_cnt_reg + 9'd1;
                                if (op_reg == OP_READ) begin
                                    rd_data_reg  <= SPI_Rdata;
                                    rd_valid_reg <= 1'b1;
                                end
                                if (last_byte) phase_reg <= PH_STAT_OP;
                            end
                            PH_STAT_OP: phase_reg <= PH_STAT_RD;
                            PH_STAT_RD: begin
                                phase_reg <= PH_STAT_OP;
                                if (!is_prog) begin
                                    rd_data_reg  <= SPI_Rdata;
                                    rd_valid_reg <= 1'b1;
                                end else if (!poll_ready) begin
                                    poll_cnt_reg <= poll_cnt_reg + 13'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy          = (state_reg != IDLE);
    assign Cmd_Done      = (state_reg == DONE);
    assign Cmd_Err       = (state_reg == ERR);
    assign Wr_Req        = (state_reg == GAP) && (phase_reg == PH_DATA) && is_prog;
    assign Rd_Data       = rd_data_reg;
    assign Rd_Valid      = rd_valid_reg;
    assign SPI_Start_Sig = start_reg;
    assign SPI_Data      = spi_data_reg;

endmodule
